// File: rtl/wb_data_ram_slave.sv
// Wishbone classic slave wrapping a byte-writable 32-bit RAM with programmable wait states.
// Optional feature: define WB_DATA_RAM_ERR_EN to error-terminate accesses outside the RAM.
module wb_data_ram_slave #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [3:0]            r_cnt;
   logic                  r_we;
   logic [31:0]           r_adr;
   logic [3:0]            r_sel;
   logic [31:0]           r_wdat;
   logic [31:0]           r_dat_o;
   logic                  r_ack;
   logic                  r_err;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_enter_resp;
   logic                  w_req_we;
   logic [31:0]           w_req_adr;
   logic [3:0]            w_req_sel;
   logic [31:0]           w_req_dat;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_adr_err;
   logic                  w_ack_d;
   logic                  w_err_d;
   logic                  w_mem_we;
   logic                  w_rd_load;

   assign w_accept     = (r_state == S_IDLE) && wb_cyc_i && wb_stb_i;
   assign w_enter_resp = (w_next_state == S_RESP) && !rst;

   // With zero wait states RESP is entered on the accepting edge, before the latches hold the request.
   assign w_req_we  = (r_state == S_IDLE) ? wb_we_i  : r_we;
   assign w_req_adr = (r_state == S_IDLE) ? wb_adr_i : r_adr;
   assign w_req_sel = (r_state == S_IDLE) ? wb_sel_i : r_sel;
   assign w_req_dat = (r_state == S_IDLE) ? wb_dat_i : r_wdat;
   assign w_idx     = w_req_adr[DEPTH_LOG2+1:2];

`ifdef WB_DATA_RAM_ERR_EN
   logic [1:0] w_unused_adr;
   assign w_unused_adr = w_req_adr[1:0];
   assign w_adr_err    = |w_req_adr[31:DEPTH_LOG2+2];
`else
   logic w_unused_adr;
   assign w_unused_adr = ^{w_req_adr[31:DEPTH_LOG2+2], w_req_adr[1:0]};
   assign w_adr_err    = 1'b0;
`endif

   // State register plus the registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat_o <= 32'h0;
      end else begin
         r_state <= w_next_state;
         r_ack   <= w_ack_d;
         r_err   <= w_err_d;
         if (w_accept) begin
            r_cnt <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_rd_load) begin
            r_dat_o <= r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we   <= wb_we_i;
         r_adr  <= wb_adr_i;
         r_sel  <= wb_sel_i;
         r_wdat <= wb_dat_i;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns the signal and no latch is inferred.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               w_next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               w_next_state = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_ack_d   = w_enter_resp && !w_adr_err;
      w_err_d   = w_enter_resp && w_adr_err;
      w_mem_we  = w_enter_resp && w_req_we && !w_adr_err;
      w_rd_load = w_enter_resp && !w_req_we && !w_adr_err;
   end

   // NOTE: the RAM array is deliberately not reset so it maps onto block RAM and survives rst.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_req_sel[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_req_dat[8*b +: 8];
            end
         end
      end
   end

   assign wb_dat_o = r_dat_o;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Directed bench for wb_data_ram_slave: instance 0 uses defaults, instance 1 uses WAIT_STATES=3.
// Expectations follow WB_DATA_RAM_ERR_EN when the bench is built with it.
module tb_wb_data_ram_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc   [2];
   logic        stb   [2];
   logic        we    [2];
   logic [31:0] adr   [2];
   logic [3:0]  sel   [2];
   logic [31:0] wdat  [2];
   logic [31:0] dat_o [2];
   logic        ack   [2];
   logic        err   [2];

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   wb_data_ram_slave u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (cyc[0]),
      .wb_stb_i (stb[0]),
      .wb_we_i  (we[0]),
      .wb_adr_i (adr[0]),
      .wb_sel_i (sel[0]),
      .wb_dat_i (wdat[0]),
      .wb_dat_o (dat_o[0]),
      .wb_ack_o (ack[0]),
      .wb_err_o (err[0])
   );

   wb_data_ram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (cyc[1]),
      .wb_stb_i (stb[1]),
      .wb_we_i  (we[1]),
      .wb_adr_i (adr[1]),
      .wb_sel_i (sel[1]),
      .wb_dat_i (wdat[1]),
      .wb_dat_o (dat_o[1]),
      .wb_ack_o (ack[1]),
      .wb_err_o (err[1])
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // One complete transfer, starting and ending on a falling edge. Inputs are scrambled after
   // acceptance to show the latched request is what gets executed.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] v, input logic exp_err, input string tag);
      int lat = 0;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = v;
      @(posedge clk);
      #1;
      stb[d] = 1'b0; we[d] = ~w; adr[d] = ~a; sel[d] = ~s; wdat[d] = ~v;
      for (int k = 1; k <= 24 && lat == 0; k++) begin
         @(negedge clk);
         if (ack[d] || err[d]) lat = k;
      end
      check({tag, "_latency"}, lat, ws_of(d) + 1);
      check({tag, "_ack"}, {31'b0, ack[d]}, {31'b0, !exp_err});
      check({tag, "_err"}, {31'b0, err[d]}, {31'b0, exp_err});
      @(negedge clk);
      check({tag, "_one_cycle"}, {31'b0, ack[d] | err[d]}, 32'd0);
      cyc[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; sel[d] = '0; wdat[d] = '0;
   endtask

   task automatic rd(input int d, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] exp_v, input string tag);
      xfer(d, 1'b0, a, s, 32'h0, 1'b0, tag);
      check({tag, "_data"}, dat_o[d], exp_v);
   endtask

   logic        exp_err_hi;
   logic [31:0] exp_word0;
   logic        seen;

   initial begin
`ifdef WB_DATA_RAM_ERR_EN
      exp_err_hi = 1'b1;
      exp_word0  = 32'h0102_0304;
`else
      exp_err_hi = 1'b0;
      exp_word0  = 32'hA5A5_A5A5;
`endif
      for (int d = 0; d < 2; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; sel[d] = '0; wdat[d] = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_ack%0d", d), {31'b0, ack[d]}, 32'd0);
         check($sformatf("reset_err%0d", d), {31'b0, err[d]}, 32'd0);
         check($sformatf("reset_dat%0d", d), dat_o[d], 32'h0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Basic write/read, partial writes, ignored low address bits, sel ignored on reads.
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, "wr10");
      check("wr10_dat_o_held", dat_o[0], 32'h0);
      rd(0, 32'h10, 4'hF, 32'hDEAD_BEEF, "rd10");
      xfer(0, 1'b1, 32'h10, 4'h1, 32'h0000_0055, 1'b0, "wr10_b0");
      rd(0, 32'h10, 4'hF, 32'hDEAD_BE55, "rd10_b0");
      xfer(0, 1'b1, 32'h14, 4'hF, 32'h1111_1111, 1'b0, "wr14");
      xfer(0, 1'b1, 32'h14, 4'h6, 32'hAABB_CCDD, 1'b0, "wr14_mid");
      check("wr14_dat_o_held", dat_o[0], 32'hDEAD_BE55);
      xfer(0, 1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF, 1'b0, "wr14_nosel");
      rd(0, 32'h17, 4'h0, 32'h11BB_CC11, "rd17");

      // Out-of-range address: error termination or aliasing onto word 0.
      xfer(0, 1'b1, 32'h0, 4'hF, 32'h0102_0304, 1'b0, "wr0");
      xfer(0, 1'b1, 32'h1000, 4'hF, 32'hA5A5_A5A5, exp_err_hi, "wr1000");
      check("wr1000_dat_o_held", dat_o[0], 32'h11BB_CC11);
      rd(0, 32'h0, 4'hF, exp_word0, "rd0");

      // Reset while a write sits in WAIT.
      xfer(0, 1'b1, 32'h40, 4'hF, 32'h0BAD_F00D, 1'b0, "wr40");
      rd(0, 32'h40, 4'hF, 32'h0BAD_F00D, "rd40_pre");
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h40; sel[0] = 4'hF;
      wdat[0] = 32'h1234_5678;
      @(posedge clk);
      #1;
      stb[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc[0] = 1'b0;
      @(negedge clk);
      check("rst_wait_ack", {31'b0, ack[0]}, 32'd0);
      check("rst_wait_err", {31'b0, err[0]}, 32'd0);
      check("rst_wait_dat", dat_o[0], 32'h0);
      @(negedge clk);
      rd(0, 32'h40, 4'hF, 32'h0BAD_F00D, "rd40_post");

      // Three wait states: latency, then abort by dropping cyc in WAIT.
      xfer(1, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, "ws3_wr20");
      rd(1, 32'h20, 4'hF, 32'h1122_3344, "ws3_rd20");
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; sel[1] = 4'hF;
      wdat[1] = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      stb[1] = 1'b0;
      @(posedge clk);
      #1;
      cyc[1] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         seen = seen | ack[1] | err[1];
      end
      check("ws3_abort_no_ack", {31'b0, seen}, 32'd0);
      rd(1, 32'h20, 4'hF, 32'h1122_3344, "ws3_rd20_after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/wb_data_ram_slave.md
WB_DATA_RAM_SLAVE -- requirements
Module: wb_data_ram_slave

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words (4 KiB by default).
REQ-002 Parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before each acknowledge.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wb_cyc_i  input  1  Wishbone cycle valid.
REQ-006 wb_stb_i  input  1  Wishbone strobe.
REQ-007 wb_we_i  input  1  1 = write, 0 = read.
REQ-008 wb_adr_i  input  32  byte address.
REQ-009 wb_sel_i  input  4  byte-lane enables; sel[i] covers dat[8i+7:8i].
REQ-010 wb_dat_i  input  32  write data.
REQ-011 wb_dat_o  output  32  read data, registered.
REQ-012 wb_ack_o  output  1  transfer-complete pulse, registered.
REQ-013 wb_err_o  output  1  error-termination pulse, registered; constant 0 unless the error feature is compiled in.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, WAIT and RESP.
REQ-015 In IDLE, a rising edge with wb_cyc_i & wb_stb_i high SHALL accept the request and latch wb_adr_i, wb_we_i, wb_sel_i and wb_dat_i.
- WAIT_STATES = 0: next state RESP.
- Otherwise: next state WAIT, wait counter loaded with WAIT_STATES-1.
REQ-016 In WAIT, the counter SHALL decrement each cycle; when the counter is 0 at an edge, the next state SHALL be RESP.
REQ-017 Acknowledge latency SHALL be exactly WAIT_STATES+1 cycles: the request is accepted at edge N and wb_ack_o is high for the single cycle following edge N+WAIT_STATES.
REQ-018 RESP SHALL last exactly one cycle and then return to IDLE, giving a minimum of 2 cycles per transfer; IDLE SHALL NOT accept a request in the same edge that leaves RESP.
REQ-019 Word index SHALL be the latched adr[DEPTH_LOG2+1:2]; adr[1:0] SHALL be ignored.
REQ-020 Writes SHALL commit on the edge entering RESP, updating only the bytes whose latched sel bit is 1; sel = 0000 completes with an ack and changes nothing.
REQ-021 Reads SHALL load wb_dat_o with the full addressed word on the edge entering RESP, regardless of sel. wb_dat_o SHALL hold that value until the next read response and SHALL be unchanged by writes.
REQ-022 Inputs that change after acceptance SHALL have no effect on the transfer in progress.
REQ-023 If wb_cyc_i is low at any edge while in WAIT, the block SHALL abort to IDLE, discarding the write and asserting no ack.
REQ-024 wb_ack_o and wb_err_o SHALL never be high in the same cycle.

Reset
REQ-025 While rst is high at an edge, the block SHALL set the state to IDLE, the wait counter to 0, wb_ack_o to 0, wb_err_o to 0 and wb_dat_o to 32'h0.
REQ-026 A reset during WAIT or RESP SHALL discard the pending transfer; a write not yet committed SHALL NOT occur.
REQ-027 Memory contents SHALL NOT be reset.

Configuration
REQ-028 Macro WB_DATA_RAM_ERR_EN controls the error-termination feature.
- Defined: a latched address with any bit of adr[31:DEPTH_LOG2+2] set SHALL terminate in RESP with wb_err_o pulsed instead of wb_ack_o, with no memory write and wb_dat_o unchanged. Latency is the same as for an ack.
- Undefined: the upper address bits SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2, and wb_err_o SHALL be tied to 0.

Verification
REQ-029 Defaults; write adr 0x10, data 0xDEADBEEF, sel 1111 accepted at edge N -> ack high only after edge N+1; a later read of 0x10 returns 0xDEADBEEF with ack after edge M+1.
REQ-030 After REQ-029, write 0x00000055 to adr 0x10 with sel 0001 -> a read of 0x10 returns 0xDEADBE55.
REQ-031 WAIT_STATES=3; read accepted at edge N -> ack high only after edge N+3, exactly one cycle wide; wb_cyc_i dropped after edge N+1 -> no ack, and the memory word is unchanged.
REQ-032 Write accepted, then rst high during WAIT -> ack, err and dat_o are 0 next cycle and the location keeps its old value.
REQ-033 With WB_DATA_RAM_ERR_EN, write to 0x00001000 (DEPTH_LOG2=10) -> wb_err_o pulses and word 0 is unchanged. Without the macro, the same write acks and updates word 0.
